// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between N_REQ byte producers.
// Latency: request seen in IDLE cycle t -> ack/tx_start/tx_data/owner in t+1.
// Backpressure: requests are only sampled in IDLE; busy transmitter holds the grant.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [N_REQ-1:0]   owner,
    output logic               timeout_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    last_q, last_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic [N_REQ-1:0] owner_q, owner_d;
    logic             timeout_err_q, timeout_err_d;

    logic             sel_vld;
    logic [IW-1:0]    sel_idx;
    logic [IW-1:0]    cand_idx;

    // Round-robin search: first pending requester after the previous grant.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        cand_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_idx = IW'((int'(last_q) + i) % N_REQ);
            if (!sel_vld && req[cand_idx]) begin
                sel_vld = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    // Next-state and registered-output logic for the grant/transmit cycle.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        owner_d       = owner_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    tx_data_d  = req_data[8*int'(sel_idx) +: 8];
                    ack_d      = N_REQ'(1) << sel_idx;
                    tx_start_d = 1'b1;
                    owner_d    = N_REQ'(1) << sel_idx;
                    last_d     = sel_idx;
                    cnt_d      = '0;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // Busy wins over a timeout landing in the same cycle.
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if ({1'b0, cnt_q} + 9'd1 == 9'(TIMEOUT)) begin
                        timeout_err_d = 1'b1;
                        owner_d       = '0;
                        state_d       = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    owner_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                owner_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; last starts at N_REQ-1 so slot 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= IW'(N_REQ - 1);
            cnt_q         <= '0;
            ack_q         <= '0;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            owner_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            owner_q       <= owner_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ack         = ack_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;

endmodule
